// File: rtl/if_stage_if.sv
// IF<->ID handshake, branch feedback and instruction-SRAM port bundle for the fetch stage.
// master = fetch stage side, slave = decode/SRAM side.
interface if_stage_if;
    logic        ds_allowin;
    logic [33:0] br_bus;           // {br_stall, br_taken, br_target}
    logic        fs_to_ds_valid;
    logic [63:0] fs_to_ds_bus;     // {fs_pc, fs_inst}
    logic        inst_sram_en;
    logic [3:0]  inst_sram_we;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;
    logic [31:0] inst_sram_rdata;

    modport master (
        input  ds_allowin, br_bus, inst_sram_rdata,
        output fs_to_ds_valid, fs_to_ds_bus,
        output inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );

    modport slave (
        output ds_allowin, br_bus, inst_sram_rdata,
        input  fs_to_ds_valid, fs_to_ds_bus,
        input  inst_sram_en, inst_sram_we, inst_sram_addr, inst_sram_wdata
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: PC generation, sync SRAM read, {pc,inst} to decode; 1-cycle issue-to-valid.
// Holds on ~ds_allowin; IF_INST_BUF_EN keeps the held word in a local buffer instead of re-reading SRAM.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic clk,
    input  logic resetn,
    if_stage_if.master bus
);
    logic        br_stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        to_fs_valid;
    logic        fs_allowin;
    logic        issue;
    logic [31:0] nextpc;
    logic [31:0] fs_inst;

    logic        fs_valid_q,    fs_valid_d;
    logic [31:0] fs_pc_q,       fs_pc_d;
    logic        pend_valid_q,  pend_valid_d;
    logic [31:0] pend_target_q, pend_target_d;

    assign br_stall  = bus.br_bus[33];
    assign br_taken  = bus.br_bus[32];
    assign br_target = bus.br_bus[31:0];

    // resetn gates issue so the SRAM stays idle for the whole reset window.
    assign to_fs_valid = resetn & ~br_stall;
    assign fs_allowin  = ~fs_valid_q | bus.ds_allowin;
    assign issue       = to_fs_valid & fs_allowin;

    always_comb begin
        nextpc = fs_pc_q + 32'd4;
        if (br_taken) begin
            nextpc = br_target;
        end else if (pend_valid_q) begin
            nextpc = pend_target_q;
        end
    end

    always_comb begin
        fs_valid_d    = fs_valid_q;
        fs_pc_d       = fs_pc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
        if (fs_allowin) begin
            fs_valid_d = to_fs_valid;
        end
        if (issue) begin
            fs_pc_d      = nextpc;
            pend_valid_d = 1'b0;
        end else if (br_taken) begin
            // Latest redirect wins if one is already pending.
            pend_valid_d  = 1'b1;
            pend_target_d = br_target;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fs_valid_q    <= 1'b0;
            fs_pc_q       <= RESET_PC - 32'd4;
            pend_valid_q  <= 1'b0;
            pend_target_q <= 32'd0;
        end else begin
            fs_valid_q    <= fs_valid_d;
            fs_pc_q       <= fs_pc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef IF_INST_BUF_EN
    logic        buf_valid_q, buf_valid_d;
    logic [31:0] buf_q,       buf_d;

    always_comb begin
        buf_valid_d = buf_valid_q;
        buf_d       = buf_q;
        if (fs_valid_q & bus.ds_allowin) begin
            buf_valid_d = 1'b0;
        end else if (fs_valid_q & ~bus.ds_allowin & ~buf_valid_q) begin
            buf_valid_d = 1'b1;
            buf_d       = bus.inst_sram_rdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_valid_q <= 1'b0;
            buf_q       <= 32'd0;
        end else begin
            buf_valid_q <= buf_valid_d;
            buf_q       <= buf_d;
        end
    end

    assign fs_inst            = buf_valid_q ? buf_q : bus.inst_sram_rdata;
    assign bus.inst_sram_en   = issue;
    assign bus.inst_sram_addr = nextpc;
`else
    logic hold_reread;

    // Without a buffer the held word is refetched every stalled cycle to keep rdata live.
    assign hold_reread        = fs_valid_q & ~fs_allowin;
    assign fs_inst            = bus.inst_sram_rdata;
    assign bus.inst_sram_en   = hold_reread | issue;
    assign bus.inst_sram_addr = hold_reread ? fs_pc_q : nextpc;
`endif

    assign bus.inst_sram_we    = 4'b0000;
    assign bus.inst_sram_wdata = 32'd0;
    assign bus.fs_to_ds_valid  = fs_valid_q;
    assign bus.fs_to_ds_bus    = {fs_pc_q, fs_inst};
endmodule
